// File: rtl/sr_flag_pkg.sv
// Shared helpers for the sr_flag_bank slice: FIRST width and lowest-index encoder.
package sr_flag_pkg;

  // Width of the FIRST index: clog2 of the channel count, never below 1.
  function automatic int unsigned first_w(input int unsigned n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

  function automatic logic [4:0] lowest_set(input logic [31:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sr_flag_cell.sv
// One set/reset flag channel: optional SET synchroniser (SR_FLAG_BANK_SYNC_EN),
// edge history, flag and sticky overrun flops.
module sr_flag_cell #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          SET_PRIO    = 1'b1,
  parameter bit          EDGE_MODE   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic set_i,
  input  logic clr_i,
  output logic flag_o,
  output logic ovr_o
);

  logic s;
  logic s_d_q;
  logic ev;
  logic flag_q, flag_d;
  logic ovr_q, ovr_d;

`ifdef SR_FLAG_BANK_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], set_i};
  end

  assign s = sync_q[SYNC_STAGES-1];
`else
  assign s = set_i;
`endif

  // s_d_q runs alongside the flag, so edge mode costs no extra latency.
  assign ev = EDGE_MODE ? (s & ~s_d_q) : s;

  always_comb begin
    flag_d = flag_q;
    ovr_d  = ovr_q;
    if (clr_i) begin
      flag_d = ev ? SET_PRIO : 1'b0;
      ovr_d  = 1'b0;
    end else begin
      if (ev) flag_d = 1'b1;
      ovr_d = ovr_q | (ev & flag_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_d_q  <= 1'b0;
      flag_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      s_d_q  <= s;
      flag_q <= flag_d;
      ovr_q  <= ovr_d;
    end
  end

  assign flag_o = flag_q;
  assign ovr_o  = ovr_q;

endmodule

// File: rtl/sr_flag_bank.sv
// Bank of CHANNELS set/reset flags with masked IRQ and lowest-index pending encoder.
// Define SR_FLAG_BANK_SYNC_EN to put a SYNC_STAGES-deep synchroniser on every SET bit.
module sr_flag_bank
  import sr_flag_pkg::*;
#(
  parameter int unsigned          CHANNELS    = 8,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0]  SET_PRIO    = '1,
  parameter logic [CHANNELS-1:0]  EDGE_MODE   = '0,
  localparam int unsigned         FW          = first_w(CHANNELS)
) (
  input  logic                CLK,
  input  logic                nRESET,
  input  logic [CHANNELS-1:0] SET,
  input  logic [CHANNELS-1:0] CLR,
  input  logic [CHANNELS-1:0] MASK,
  output logic [CHANNELS-1:0] FLAGS,
  output logic [CHANNELS-1:0] OVR,
  output logic                IRQ,
  output logic [FW-1:0]       FIRST,
  output logic                FIRST_VALID
);

  logic [CHANNELS-1:0] flags_w;
  logic [CHANNELS-1:0] ovr_w;
  logic [CHANNELS-1:0] pending;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    sr_flag_cell #(
      .SYNC_STAGES (SYNC_STAGES),
      .SET_PRIO    (SET_PRIO[i]),
      .EDGE_MODE   (EDGE_MODE[i])
    ) u_cell (
      .clk_i  (CLK),
      .rst_ni (nRESET),
      .set_i  (SET[i]),
      .clr_i  (CLR[i]),
      .flag_o (flags_w[i]),
      .ovr_o  (ovr_w[i])
    );
  end

  assign pending     = flags_w & MASK;
  assign FLAGS       = flags_w;
  assign OVR         = ovr_w;
  assign IRQ         = |pending;
  assign FIRST_VALID = |pending;
  assign FIRST       = FW'(lowest_set(32'(pending)));

endmodule
